// File: rtl/kbd_pkg.sv
// Shared scancode constants and repeat-FSM state type for the keyboard ASCII FIFO.
package kbd_pkg;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    // Modifier keys only change state and are never turned into characters.
    function automatic logic is_modifier(input logic [7:0] code);
        return (code == SC_LSHIFT) || (code == SC_RSHIFT) ||
               (code == SC_CTRL)   || (code == SC_CAPS);
    endfunction

endpackage

// File: rtl/key_ascii_fifo_if.sv
// Keyboard event input, FIFO read port and status bits of key_ascii_fifo.
interface key_ascii_fifo_if;

    logic [7:0] key_code;
    logic       key_down;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       overflow;
    logic       caps_on;
    logic       shift_on;
    logic       ctrl_on;

    // Driver side: keyboard front-end plus CPU read port.
    modport master (
        output key_code, key_down, rd_en,
        input  rd_data, empty, overflow, caps_on, shift_on, ctrl_on
    );

    // The FIFO block itself.
    modport slave (
        input  key_code, key_down, rd_en,
        output rd_data, empty, overflow, caps_on, shift_on, ctrl_on
    );

endinterface

// File: rtl/key_ascii_fifo_scancode_to_ascii.sv
// Combinational set-2 scancode to ASCII translation; 8'h00 means unmapped.
module scancode_to_ascii (
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    input  logic       ctrl,
    output logic [7:0] ascii
);

    logic       letter;
    logic [7:0] lower;
    logic [7:0] shifted;

    // Base table: unshifted glyph plus shifted glyph for non-letters.
    always_comb begin
        letter  = 1'b0;
        lower   = 8'h00;
        shifted = 8'h00;
        case (code)
            8'h1C: begin letter = 1'b1; lower = "a"; end
            8'h32: begin letter = 1'b1; lower = "b"; end
            8'h21: begin letter = 1'b1; lower = "c"; end
            8'h23: begin letter = 1'b1; lower = "d"; end
            8'h24: begin letter = 1'b1; lower = "e"; end
            8'h2B: begin letter = 1'b1; lower = "f"; end
            8'h34: begin letter = 1'b1; lower = "g"; end
            8'h33: begin letter = 1'b1; lower = "h"; end
            8'h43: begin letter = 1'b1; lower = "i"; end
            8'h3B: begin letter = 1'b1; lower = "j"; end
            8'h42: begin letter = 1'b1; lower = "k"; end
            8'h4B: begin letter = 1'b1; lower = "l"; end
            8'h3A: begin letter = 1'b1; lower = "m"; end
            8'h31: begin letter = 1'b1; lower = "n"; end
            8'h44: begin letter = 1'b1; lower = "o"; end
            8'h4D: begin letter = 1'b1; lower = "p"; end
            8'h15: begin letter = 1'b1; lower = "q"; end
            8'h2D: begin letter = 1'b1; lower = "r"; end
            8'h1B: begin letter = 1'b1; lower = "s"; end
            8'h2C: begin letter = 1'b1; lower = "t"; end
            8'h3C: begin letter = 1'b1; lower = "u"; end
            8'h2A: begin letter = 1'b1; lower = "v"; end
            8'h1D: begin letter = 1'b1; lower = "w"; end
            8'h22: begin letter = 1'b1; lower = "x"; end
            8'h35: begin letter = 1'b1; lower = "y"; end
            8'h1A: begin letter = 1'b1; lower = "z"; end
            8'h16: begin lower = "1"; shifted = "!"; end
            8'h1E: begin lower = "2"; shifted = "@"; end
            8'h26: begin lower = "3"; shifted = "#"; end
            8'h25: begin lower = "4"; shifted = "$"; end
            8'h2E: begin lower = "5"; shifted = "%"; end
            8'h36: begin lower = "6"; shifted = "^"; end
            8'h3D: begin lower = "7"; shifted = "&"; end
            8'h3E: begin lower = "8"; shifted = "*"; end
            8'h46: begin lower = "9"; shifted = "("; end
            8'h45: begin lower = "0"; shifted = ")"; end
            8'h4E: begin lower = "-"; shifted = "_"; end
            8'h55: begin lower = "="; shifted = "+"; end
            8'h54: begin lower = "["; shifted = "{"; end
            8'h5B: begin lower = "]"; shifted = "}"; end
            8'h5D: begin lower = 8'h5C; shifted = 8'h7C; end  // backslash / bar
            8'h4C: begin lower = ";"; shifted = ":"; end
            8'h52: begin lower = 8'h27; shifted = 8'h22; end  // quote / double quote
            8'h41: begin lower = ","; shifted = "<"; end
            8'h49: begin lower = "."; shifted = ">"; end
            8'h4A: begin lower = "/"; shifted = "?"; end
            8'h0E: begin lower = 8'h60; shifted = "~"; end
            8'h29: begin lower = " "; shifted = " "; end
            8'h5A: begin lower = 8'h0D; shifted = 8'h0D; end  // enter
            8'h66: begin lower = 8'h08; shifted = 8'h08; end  // backspace
            8'h0D: begin lower = 8'h09; shifted = 8'h09; end  // tab
            8'h76: begin lower = 8'h1B; shifted = 8'h1B; end  // escape
            default: ;
        endcase
    end

    // Apply case, shift and control modifiers.
    always_comb begin
        ascii = 8'h00;
        if (letter) begin
            ascii = (shift ^ caps) ? (lower - 8'h20) : lower;
            if (ctrl) begin
                ascii = ascii & 8'h1F;
            end
        end else begin
            ascii = shift ? shifted : lower;
        end
    end

endmodule

// File: rtl/key_ascii_fifo.sv
// Keyboard event to ASCII FIFO with modifier tracking.
// Optional auto-repeat is built when KEY_REPEAT_EN is defined.
module key_ascii_fifo
    import kbd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 2_500_000
) (
    input logic              clk,
    input logic              clrn,
    key_ascii_fifo_if.slave  bus
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [7:0]  prev_code;
    logic        prev_down;
    logic        key_event;
    logic        is_make;
    logic        is_mod;
    logic        ev_push;
    logic        lshift, rshift, ctrl, caps;
    logic [7:0]  ascii;

    logic        stage_valid, stage_valid_d;
    logic [7:0]  stage_char, stage_char_d;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, fifo_empty, push, pop, overflow;

    // New event when input pair changes to a non-zero scancode.
    always_comb begin
        key_event = ({bus.key_code, bus.key_down} != {prev_code, prev_down}) &&
                    (bus.key_code != 8'h00);
        is_make   = key_event && bus.key_down;
        is_mod    = is_modifier(bus.key_code);
        ev_push   = is_make && !is_mod && (ascii != 8'h00);
    end

    // Previous-input register follows the inputs every cycle.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            prev_code <= 8'h00;
            prev_down <= 1'b0;
        end else begin
            prev_code <= bus.key_code;
            prev_down <= bus.key_down;
        end
    end

    // Modifier state; translation below sees the value before this event.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            lshift <= 1'b0;
            rshift <= 1'b0;
            ctrl   <= 1'b0;
            caps   <= 1'b0;
        end else if (key_event) begin
            case (bus.key_code)
                SC_LSHIFT: lshift <= bus.key_down;
                SC_RSHIFT: rshift <= bus.key_down;
                SC_CTRL:   ctrl   <= bus.key_down;
                SC_CAPS:   if (bus.key_down) caps <= ~caps;
                default: ;
            endcase
        end
    end

    scancode_to_ascii u_xlate (
        .code  (bus.key_code),
        .shift (lshift | rshift),
        .caps  (caps),
        .ctrl  (ctrl),
        .ascii (ascii)
    );

`ifdef KEY_REPEAT_EN
    rpt_state_t  rpt_state;
    logic [31:0] rpt_cnt;
    logic [7:0]  rpt_code;
    logic [7:0]  rpt_char;
    logic        rpt_cancel;
    logic        rpt_fire;

    // A break of the held key cancels; an event push pre-empts the repeat push.
    always_comb begin
        rpt_cancel = key_event && !bus.key_down && (bus.key_code == rpt_code) &&
                     (rpt_state != IDLE);
        rpt_fire   = (rpt_state != IDLE) && (rpt_cnt == 32'd0) && !rpt_cancel && !ev_push;
    end

    // Repeat FSM: latch last printable make, count delay, then period.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            rpt_state <= IDLE;
            rpt_cnt   <= 32'd0;
            rpt_code  <= 8'h00;
            rpt_char  <= 8'h00;
        end else if (ev_push) begin
            rpt_state <= DELAY;
            rpt_cnt   <= REPEAT_DELAY - 32'd1;
            rpt_code  <= bus.key_code;
            rpt_char  <= ascii;
        end else if (rpt_cancel) begin
            rpt_state <= IDLE;
            rpt_cnt   <= 32'd0;
        end else if (rpt_state != IDLE) begin
            if (rpt_cnt == 32'd0) begin
                rpt_state <= REPEAT;
                rpt_cnt   <= REPEAT_PERIOD - 32'd1;
            end else begin
                rpt_cnt <= rpt_cnt - 32'd1;
            end
        end
    end

    // Select what enters the write stage: event first, then repeat.
    always_comb begin
        stage_valid_d = ev_push || rpt_fire;
        stage_char_d  = ev_push ? ascii : rpt_char;
    end
`else
    // Select what enters the write stage.
    always_comb begin
        stage_valid_d = ev_push;
        stage_char_d  = ascii;
    end
`endif

    // One-cycle write stage gives the push at the edge after detection.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            stage_valid <= 1'b0;
            stage_char  <= 8'h00;
        end else begin
            stage_valid <= stage_valid_d;
            stage_char  <= stage_char_d;
        end
    end

    // FIFO flags; a full FIFO still accepts a push when popped in the same cycle.
    always_comb begin
        fifo_empty = (wr_ptr == rd_ptr);
        full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop        = bus.rd_en && !fifo_empty;
        push       = stage_valid && (!full || pop);
    end

    // Storage array; contents are don't-care while not between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= stage_char;
        end
    end

    // Pointers and sticky overflow.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (stage_valid && full && !pop) overflow <= 1'b1;
        end
    end

    assign bus.rd_data  = fifo_empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
    assign bus.empty    = fifo_empty;
    assign bus.overflow = overflow;
    assign bus.caps_on  = caps;
    assign bus.shift_on = lshift | rshift;
    assign bus.ctrl_on  = ctrl;

endmodule

// File: tb/tb_key_ascii_fifo.sv
// Directed bench for key_ascii_fifo; repeat test selected by KEY_REPEAT_EN.
module tb_key_ascii_fifo;

    logic clk = 1'b0;
    logic clrn;

    always #5 clk = ~clk;

    key_ascii_fifo_if kif ();

    key_ascii_fifo #(
        .FIFO_DEPTH    (16),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (5)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (kif)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Make event for one cycle, then back to "no code"; entry visible on return.
    task automatic press(input logic [7:0] c);
        kif.key_code = c;
        kif.key_down = 1'b1;
        @(negedge clk);
        kif.key_code = 8'h00;
        kif.key_down = 1'b0;
        @(negedge clk);
    endtask

    task automatic release_key(input logic [7:0] c);
        kif.key_code = c;
        kif.key_down = 1'b0;
        @(negedge clk);
        kif.key_code = 8'h00;
        @(negedge clk);
    endtask

    task automatic pop_one();
        kif.rd_en = 1'b1;
        @(negedge clk);
        kif.rd_en = 1'b0;
    endtask

    task automatic expect_pop(input string tag, input logic [7:0] exp);
        check_eq(tag, kif.rd_data, exp);
        pop_one();
    endtask

    logic [7:0] fill_codes [17] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15};

    initial begin
        clrn         = 1'b0;
        kif.key_code = 8'h00;
        kif.key_down = 1'b0;
        kif.rd_en    = 1'b0;
        cyc(3);
        check_eq("rst_empty", kif.empty, 1);
        check_eq("rst_rd_data", kif.rd_data, 8'h00);
        check_eq("rst_overflow", kif.overflow, 0);
        check_eq("rst_caps", kif.caps_on, 0);
        check_eq("rst_shift", kif.shift_on, 0);
        check_eq("rst_ctrl", kif.ctrl_on, 0);
        clrn = 1'b1;
        cyc(1);

`ifdef KEY_REPEAT_EN
        begin
            int times [8];
            int nt = 0;
            int late = 0;
            kif.key_code = 8'h1C;
            kif.key_down = 1'b1;
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                kif.rd_en = 1'b0;
                if (!kif.empty) begin
                    if (nt < 8) times[nt] = c;
                    nt++;
                    check_eq("rpt_char", kif.rd_data, 8'h61);
                    kif.rd_en = 1'b1;
                end
            end
            check_eq("rpt_count", nt, 5);
            check_eq("rpt_t0", times[0], 2);
            check_eq("rpt_t1", times[1], 22);
            check_eq("rpt_t2", times[2], 27);
            check_eq("rpt_t3", times[3], 32);
            check_eq("rpt_t4", times[4], 37);
            kif.key_down = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                kif.rd_en = 1'b0;
                if (!kif.empty) begin
                    late++;
                    kif.rd_en = 1'b1;
                end
            end
            check_eq("rpt_after_break", late, 0);
            kif.rd_en = 1'b0;
        end
`else
        // Latency: nothing after the detect edge, entry after the next one.
        kif.key_code = 8'h1C;
        kif.key_down = 1'b1;
        @(negedge clk);
        check_eq("lat_not_yet", kif.empty, 1);
        kif.key_code = 8'h00;
        kif.key_down = 1'b0;
        @(negedge clk);
        check_eq("lat_empty", kif.empty, 0);
        release_key(8'h1C);
        expect_pop("a_lower", 8'h61);
        check_eq("a_break_no_push", kif.empty, 1);

        // Shift alone pushes nothing.
        press(8'h12);
        check_eq("lshift_on", kif.shift_on, 1);
        check_eq("lshift_no_push", kif.empty, 1);
        press(8'h1C);
        expect_pop("a_shift", 8'h41);
        release_key(8'h12);
        check_eq("lshift_off", kif.shift_on, 0);

        // Caps toggles on make only; digits unaffected.
        press(8'h58);
        release_key(8'h58);
        check_eq("caps_on", kif.caps_on, 1);
        check_eq("caps_no_push", kif.empty, 1);
        press(8'h16);
        expect_pop("digit_caps", 8'h31);
        press(8'h1C);
        expect_pop("a_caps", 8'h41);
        press(8'h12);
        press(8'h1C);
        expect_pop("a_caps_shift", 8'h61);
        release_key(8'h12);
        press(8'h58);
        release_key(8'h58);
        check_eq("caps_off", kif.caps_on, 0);

        // Ctrl letter.
        press(8'h14);
        check_eq("ctrl_on", kif.ctrl_on, 1);
        press(8'h21);
        expect_pop("ctrl_c", 8'h03);
        release_key(8'h14);
        check_eq("ctrl_off", kif.ctrl_on, 0);

        // Right shift with punctuation.
        press(8'h59);
        press(8'h1E);
        expect_pop("shift_2", 8'h40);
        press(8'h4A);
        expect_pop("shift_slash", 8'h3F);
        release_key(8'h59);
        check_eq("rshift_off", kif.shift_on, 0);

        // Pop on empty is ignored, also when it coincides with a push.
        pop_one();
        check_eq("pop_empty", kif.empty, 1);
        kif.key_code = 8'h1C;
        kif.key_down = 1'b1;
        @(negedge clk);
        kif.key_code = 8'h00;
        kif.key_down = 1'b0;
        kif.rd_en    = 1'b1;
        @(negedge clk);
        kif.rd_en = 1'b0;
        check_eq("push_pop_empty", kif.empty, 0);
        expect_pop("push_pop_empty_data", 8'h61);

        // Overflow: 17 pushes keep the first 16.
        for (int i = 0; i < 17; i++) press(fill_codes[i]);
        check_eq("ovf_flag", kif.overflow, 1);
        check_eq("ovf_head", kif.rd_data, 8'h61);
        // Push 'r' while popping a full FIFO: nothing dropped.
        kif.key_code = 8'h2D;
        kif.key_down = 1'b1;
        @(negedge clk);
        kif.key_code = 8'h00;
        kif.key_down = 1'b0;
        kif.rd_en    = 1'b1;
        @(negedge clk);
        kif.rd_en = 1'b0;
        for (int i = 1; i < 16; i++) expect_pop("ovf_order", 8'h61 + 8'(i));
        expect_pop("full_push_pop", 8'h72);
        check_eq("ovf_drained", kif.empty, 1);
        check_eq("ovf_sticky", kif.overflow, 1);

        // Reset mid-FIFO.
        press(8'h58);
        release_key(8'h58);
        for (int i = 0; i < 5; i++) press(fill_codes[i]);
        check_eq("pre_rst_full5", kif.empty, 0);
        clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        check_eq("mid_rst_empty", kif.empty, 1);
        check_eq("mid_rst_overflow", kif.overflow, 0);
        check_eq("mid_rst_caps", kif.caps_on, 0);
        check_eq("mid_rst_rd_data", kif.rd_data, 8'h00);
        press(8'h32);
        expect_pop("post_rst_b", 8'h62);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
